// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SERV_I = 2'd1,
        SERV_D = 2'd2,
        RESP   = 2'd3
    } state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

    localparam int unsigned TIMEOUT_DEFAULT = 256;
    localparam int unsigned WAIT_W          = 16;

    // On a collision the requester that did not win last time gets the bus.
    function automatic grant_t pick_grant(input logic i_req, input logic d_req,
                                          input grant_t last);
        grant_t g;
        if (i_req && d_req) begin
            if (last == GRANT_I) g = GRANT_D;
            else                 g = GRANT_I;
        end else if (d_req) begin
            g = GRANT_D;
        end else begin
            g = GRANT_I;
        end
        return g;
    endfunction

endpackage

// File: rtl/arb_wait_timer.sv
// Counts memory wait cycles of the transaction in flight; expire flags TIMEOUT-1.
module arb_wait_timer
    import mem_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(TIMEOUT - 1);

    logic [WAIT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign expire = (count == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and data access onto one memory port with
// alternating priority on collisions and a wait timeout.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ready,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_wen,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ready,
    output logic [31:0] d_rdata,
    output logic        err,
    output logic        mem_cen,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    state_t state, state_next;
    grant_t last_grant, grant_sel;
    logic   grant, done, abort, expire, serving, timed_out;

    assign serving = (state == SERV_I) || (state == SERV_D);

    arb_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (grant),
        .enable (serving && !mem_ready),
        .expire (expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // mem_ready wins over an expiring counter in the same cycle.
    always_comb begin
        state_next = state;
        grant      = 1'b0;
        done       = 1'b0;
        abort      = 1'b0;
        grant_sel  = pick_grant(i_req, d_req, last_grant);
        case (state)
            IDLE: begin
                if (i_req || d_req) begin
                    grant      = 1'b1;
                    state_next = (grant_sel == GRANT_D) ? SERV_D : SERV_I;
                end
            end
            SERV_I, SERV_D: begin
                if (mem_ready) begin
                    done       = 1'b1;
                    state_next = RESP;
                end else if (expire) begin
                    abort      = 1'b1;
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= GRANT_I;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wen    <= 1'b0;
            i_rdata    <= '0;
            d_rdata    <= '0;
            timed_out  <= 1'b0;
        end else begin
            if (grant) begin
                last_grant <= grant_sel;
                timed_out  <= 1'b0;
                if (grant_sel == GRANT_D) begin
                    mem_addr  <= d_addr;
                    mem_wen   <= d_wen;
                    mem_wdata <= d_wdata;
                end else begin
                    mem_addr  <= i_addr;
                    mem_wen   <= 1'b0;
                end
            end
            if (done) begin
                if (state == SERV_I)  i_rdata <= mem_rdata;
                else if (!mem_wen)    d_rdata <= mem_rdata;
            end
            if (abort) timed_out <= 1'b1;
        end
    end

    // last_grant still names the served requester while in RESP.
    assign mem_cen = serving;
    assign i_ready = (state == RESP) && (last_grant == GRANT_I);
    assign d_ready = (state == RESP) && (last_grant == GRANT_D);
    assign err     = (state == RESP) && timed_out;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench for mem_arbiter: stimulus pushes expected
// responses, a negedge monitor pops them whenever a ready pulse appears.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req, d_wen, mem_ready;
    logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
    logic        i_ready, d_ready, err, mem_cen, mem_wen;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        is_d;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_ready   (i_ready),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_wen     (d_wen),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ready   (d_ready),
        .d_rdata   (d_rdata),
        .err       (err),
        .mem_cen   (mem_cen),
        .mem_wen   (mem_wen),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_resp(input logic is_d, input logic [31:0] rdata, input logic e);
        exp_t x;
        x.is_d  = is_d;
        x.rdata = rdata;
        x.err   = e;
        exp_q.push_back(x);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_cen"},   32'(mem_cen),   32'd0);
        check({tag, "_mem_wen"},   32'(mem_wen),   32'd0);
        check({tag, "_i_ready"},   32'(i_ready),   32'd0);
        check({tag, "_d_ready"},   32'(d_ready),   32'd0);
        check({tag, "_err"},       32'(err),       32'd0);
        check({tag, "_mem_addr"},  mem_addr,       32'd0);
        check({tag, "_mem_wdata"}, mem_wdata,      32'd0);
        check({tag, "_i_rdata"},   i_rdata,        32'd0);
        check({tag, "_d_rdata"},   d_rdata,        32'd0);
    endtask

    // Waits (bounded) for mem_cen, checks the registered request each cycle,
    // then answers with mem_ready after 'waits' extra cycles.
    task automatic serve(input int unsigned waits, input logic [31:0] rdata,
                         input logic [31:0] addr, input logic wen,
                         input logic [31:0] wdata, input bit scramble);
        int unsigned n = 0;
        while (!mem_cen && n < 20) begin
            tick();
            n++;
        end
        check("grant_seen", 32'(mem_cen), 32'd1);
        if (!mem_cen) return;
        if (scramble) begin
            d_addr  = 32'hFFFF_FFFC;
            d_wen   = 1'b1;
            d_wdata = 32'h0BAD_0BAD;
        end
        for (int unsigned k = 0; k <= waits; k++) begin
            check("mem_addr", mem_addr, addr);
            check("mem_wen", 32'(mem_wen), 32'(wen));
            if (wen) check("mem_wdata", mem_wdata, wdata);
            if (k == waits) begin
                mem_ready = 1'b1;
                mem_rdata = rdata;
            end
            tick();
        end
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        check("cen_drop", 32'(mem_cen), 32'd0);
    endtask

    always @(negedge clk) begin
        if (i_ready || d_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_ready: got i_ready=%0b d_ready=%0b, required no pulse (t=%0t)",
                         i_ready, d_ready, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("resp_port", 32'({i_ready, d_ready}), e.is_d ? 32'd1 : 32'd2);
                check("resp_rdata", e.is_d ? d_rdata : i_rdata, e.rdata);
                check("resp_err", 32'(err), 32'(e.err));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned cnt;
        rst = 1'b1;
        i_req = 0; d_req = 0; d_wen = 0; mem_ready = 0;
        i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // Single fetch: ready in the third cycle counting the request cycle.
        expect_resp(1'b0, 32'h0000_0013, 1'b0);
        i_req = 1'b1; i_addr = 32'h0000_0010;
        serve(0, 32'h0000_0013, 32'h0000_0010, 1'b0, 32'h0, 1'b0);
        check("fetch_latency_i_ready", 32'(i_ready), 32'd1);
        i_req = 1'b0;
        tick();
        tick();

        // Collision with last grant = instruction: data first, then fetch.
        expect_resp(1'b1, 32'hAAAA_0100, 1'b0);
        expect_resp(1'b0, 32'hBBBB_0004, 1'b0);
        d_req = 1'b1; d_wen = 1'b0; d_addr = 32'h100;
        i_req = 1'b1; i_addr = 32'h4;
        serve(0, 32'hAAAA_0100, 32'h100, 1'b0, 32'h0, 1'b0);
        d_req = 1'b0;
        serve(1, 32'hBBBB_0004, 32'h4, 1'b0, 32'h0, 1'b0);
        i_req = 1'b0;
        tick();

        // Store: memory data on the bus must not reach d_rdata.
        expect_resp(1'b1, 32'hAAAA_0100, 1'b0);
        d_req = 1'b1; d_wen = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF;
        serve(2, 32'h1234_5678, 32'h200, 1'b1, 32'hDEAD_BEEF, 1'b0);
        d_req = 1'b0; d_wen = 1'b0;
        tick();

        // Collision with last grant = data: fetch first, then data.
        expect_resp(1'b0, 32'h1111_0008, 1'b0);
        expect_resp(1'b1, 32'h2222_0104, 1'b0);
        i_req = 1'b1; i_addr = 32'h8;
        d_req = 1'b1; d_addr = 32'h104;
        serve(0, 32'h1111_0008, 32'h8, 1'b0, 32'h0, 1'b0);
        i_req = 1'b0;
        serve(0, 32'h2222_0104, 32'h104, 1'b0, 32'h0, 1'b0);
        d_req = 1'b0;
        tick();

        // Timeout: 8 cycles of mem_cen, then d_ready with err; late mem_ready ignored.
        expect_resp(1'b1, 32'h2222_0104, 1'b1);
        d_req = 1'b1; d_addr = 32'h300;
        tick();
        cnt = 0;
        while (mem_cen && cnt < 20) begin
            cnt++;
            tick();
        end
        check("timeout_cen_cycles", cnt, 32'd8);
        check("timeout_d_ready", 32'(d_ready), 32'd1);
        check("timeout_err", 32'(err), 32'd1);
        d_req = 1'b0;
        mem_ready = 1'b1; mem_rdata = 32'h0000_0BAD;
        tick();
        tick();
        mem_ready = 1'b0; mem_rdata = 32'h0;
        check("late_ready_d_rdata", d_rdata, 32'h2222_0104);
        check("late_ready_cen", 32'(mem_cen), 32'd0);
        tick();

        // mem_ready on the expiry cycle completes normally; inputs change in flight.
        expect_resp(1'b1, 32'h0000_0055, 1'b0);
        d_req = 1'b1; d_wen = 1'b0; d_addr = 32'h400;
        serve(7, 32'h0000_0055, 32'h400, 1'b0, 32'h0, 1'b1);
        d_req = 1'b0; d_wen = 1'b0;
        tick();
        tick();

        // Reset in the middle of a fetch.
        i_req = 1'b1; i_addr = 32'h500;
        tick();
        check("pre_reset_cen", 32'(mem_cen), 32'd1);
        tick();
        rst = 1'b1;
        #1;
        check_all_zero("mid_reset");
        i_req = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("post_reset_cen", 32'(mem_cen), 32'd0);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 256, meaning the cycles a transaction may wait for mem_ready before it is aborted (legal range 2..65535).
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 i_req  input  1  instruction-fetch request, held until i_ready.
REQ-005 i_addr  input  32  fetch address, stable while i_req is high.
REQ-006 i_ready  output  1  one-cycle pulse: fetch complete, i_rdata valid.
REQ-007 i_rdata  output  32  fetched word, held until the next fetch completion.
REQ-008 d_req  input  1  data request, held until d_ready.
REQ-009 d_wen  input  1  high = write; low = read.
REQ-010 d_addr  input  32  data address.
REQ-011 d_wdata  input  32  store data.
REQ-012 d_ready  output  1  one-cycle pulse: data access complete.
REQ-013 d_rdata  output  32  load data, held until the next data completion.
REQ-014 err  output  1  pulses together with i_ready or d_ready when the transaction timed out.
REQ-015 mem_cen  output  1  unified memory request, high for the whole transaction.
REQ-016 mem_wen  output  1  write enable to memory, valid while mem_cen is high.
REQ-017 mem_addr  output  32  memory address, registered.
REQ-018 mem_wdata  output  32  memory write data, registered.
REQ-019 mem_rdata  input  32  memory read data, valid when mem_ready is high.
REQ-020 mem_ready  input  1  one-cycle completion pulse from memory.

Function
REQ-021 The FSM SHALL have the states IDLE, SERV_I, SERV_D and RESP.
REQ-022 In IDLE with only i_req high, the FSM SHALL latch i_addr into mem_addr, drive mem_wen low, and go to SERV_I.
REQ-023 In IDLE with only d_req high, the FSM SHALL latch d_addr, d_wen and d_wdata, and go to SERV_D.
REQ-024 When i_req and d_req are high together, the FSM SHALL grant the requester not granted last (last_grant bit); after reset, data wins.
REQ-025 mem_cen SHALL rise the cycle after the grant and stay high until the cycle mem_ready is sampled high.
REQ-026 On mem_ready in SERV_x, the FSM SHALL:
  - capture mem_rdata into x_rdata (reads only; writes leave d_rdata unchanged);
  - drop mem_cen;
  - go to RESP.
REQ-027 In RESP, the FSM SHALL assert the matching x_ready for exactly one cycle, grant nothing, then return to IDLE.
REQ-028 Minimum latency SHALL be request-to-ready of 3 cycles when mem_ready arrives on the first mem_cen cycle.
REQ-029 A requester SHALL drop req in the cycle after x_ready, or keep it high to issue a new transaction; a new grant occurs 2 cycles after ready at the earliest.
REQ-030 A wait counter SHALL clear on grant and increment each SERV cycle without mem_ready.
REQ-031 When the wait counter reaches TIMEOUT-1, the FSM SHALL abort: drop mem_cen, go to RESP, pulse x_ready with err, and leave x_rdata unchanged.
REQ-032 If mem_ready arrives in the same cycle the timeout is reached, the transaction SHALL complete normally with err low.
REQ-033 mem_ready while in IDLE or RESP SHALL be ignored.
REQ-034 Request inputs SHALL be ignored outside IDLE; changes to address/data after the grant SHALL NOT affect the transaction in flight.
REQ-035 mem_addr, mem_wdata and mem_wen SHALL hold their values after a transaction until the next grant.
REQ-036 The block SHALL pass data unmodified; byte ordering is handled by the top level.

Reset
REQ-037 On rst, asynchronously and at any point mid-transaction, the block SHALL:
  - enter IDLE;
  - set last_grant to "instruction" (so data wins next);
  - clear the wait counter;
  - drive mem_cen, mem_wen, i_ready, d_ready and err to 0;
  - drive mem_addr, mem_wdata, i_rdata and d_rdata to 0.
REQ-038 A transaction aborted by reset SHALL produce no ready pulse after reset is released.

Structure
REQ-039 State encodings, the TIMEOUT default and the grant-select encoding SHALL live in a shared package, mem_arb_pkg.
REQ-040 The wait counter SHALL be one sub-module, arb_wait_timer, with clear, enable and expire ports; everything else SHALL be flat.

Verification
REQ-041 Single fetch: i_req=1, i_addr=0x0000_0010, memory ready after 1 cycle with 0x0000_0013 -> i_ready pulses at cycle 3 and i_rdata=0x0000_0013.
REQ-042 Simultaneous requests after reset: d_req read 0x100 and i_req 0x4 -> data served first, then fetch; requests at the same time again -> fetch served first.
REQ-043 Store: d_wen=1, d_addr=0x200, d_wdata=0xDEADBEEF -> mem_wen=1 and mem_wdata=0xDEADBEEF while mem_cen is high; d_rdata unchanged.
REQ-044 Timeout with TIMEOUT=8 and no mem_ready -> mem_cen high for 8 cycles, then d_ready=1 and err=1; a mem_ready arriving later is ignored.
REQ-045 Reset asserted mid-SERV_I -> all outputs 0 immediately; no i_ready pulse after release.
REQ-046 mem_ready on the timeout cycle with mem_rdata=0x55 -> err=0 and rdata=0x55.
